fft_bfly_seq_alu: RTL and testbench

- Parametrised radix-2 complex butterfly ALU with its own step sequencer. It computes Y = A + W·B and Z = A − W·B.
- Replaces externally driven one-hot step strobes with an internal 8-step FSM and a start/done handshake.
- It consumes one real multiplier product per step over a valid/ready interface. It also offers optional saturation, output scaling and a sticky overflow flag.
- Sits between the twiddle multiplier and the FFT data memory write-back.

---
 rtl/fft_bfly_seq_alu_if.sv | 35 +++
 rtl/fft_bfly_seq_alu.sv | 159 +++++++++++++++
 tb/tb_fft_bfly_seq_alu.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bfly_seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_seq_alu_if
// Brief    : Start/product handshake and result bus of the butterfly ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bfly_seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                    start;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] p_data;
    logic                    p_valid;
    logic                    p_ready;
    logic [2:0]              step;
    logic                    busy;
    logic                    done;
    logic                    ovf;
    logic signed [WIDTH-1:0] rey;
    logic signed [WIDTH-1:0] imy;
    logic signed [WIDTH-1:0] rez;
    logic signed [WIDTH-1:0] imz;

    modport master (
        output start, a_re, a_im, p_data, p_valid,
        input  p_ready, step, busy, done, ovf, rey, imy, rez, imz
    );

    modport slave (
        input  start, a_re, a_im, p_data, p_valid,
        output p_ready, step, busy, done, ovf, rey, imy, rez, imz
    );
endinterface
`default_nettype wire

// File: rtl/fft_bfly_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_seq_alu
// Brief    : Radix-2 butterfly Y = A + W*B, Z = A - W*B built from eight
//            sequenced add/sub steps, one multiplier product per step.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bfly_seq_alu #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int SCALE    = 0
) (
    input  wire logic          clock,
    input  wire logic          n_rst,
    fft_bfly_seq_alu_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              step_q,  step_d;
    logic signed [WIDTH-1:0] acc_q,   acc_d;
    logic signed [WIDTH-1:0] a_re_q,  a_re_d;
    logic signed [WIDTH-1:0] a_im_q,  a_im_d;
    logic signed [WIDTH-1:0] rey_q,   rey_d;
    logic signed [WIDTH-1:0] imy_q,   imy_d;
    logic signed [WIDTH-1:0] rez_q,   rez_d;
    logic signed [WIDTH-1:0] imz_q,   imz_d;
    logic                    ovf_q,   ovf_d;
    logic                    done_q,  done_d;

    logic signed [WIDTH-1:0] w_op_a;
    logic signed [WIDTH:0]   w_op_ext;
    logic signed [WIDTH:0]   w_p_ext;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH:0]   w_res_wide;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_sub;
    logic                    w_is_store;
    logic                    w_out_of_range;

    // Even steps seed acc from A (re on 0/4, im on 2/6); odd steps finish from acc.
    assign w_is_store = step_q[0];
    assign w_op_a     = w_is_store ? acc_q : (step_q[1] ? a_im_q : a_re_q);
    assign w_sub      = (step_q == 3'd1) || (step_q == 3'd4) ||
                        (step_q == 3'd6) || (step_q == 3'd7);
    assign w_op_ext   = {w_op_a[WIDTH-1], w_op_a};
    assign w_p_ext    = {bus.p_data[WIDTH-1], bus.p_data};
    assign w_sum      = w_sub ? (w_op_ext - w_p_ext) : (w_op_ext + w_p_ext);

    generate
        if (SCALE != 0) begin : g_scale_on
            assign w_res_wide = w_is_store ? (w_sum >>> 1) : w_sum;
        end else begin : g_scale_off
            assign w_res_wide = w_sum;
        end
    endgenerate

    assign w_out_of_range = w_res_wide[WIDTH] ^ w_res_wide[WIDTH-1];

    generate
        if (SATURATE != 0) begin : g_sat_on
            assign w_res = !w_out_of_range ? w_res_wide[WIDTH-1:0] :
                           (w_res_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}});
        end else begin : g_sat_off
            assign w_res = w_res_wide[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        rey_d   = rey_q;
        imy_d   = imy_q;
        rez_d   = rez_q;
        imz_d   = imz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    step_d  = 3'd0;
                    a_re_d  = bus.a_re;
                    a_im_d  = bus.a_im;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (bus.p_valid) begin
                    step_d = step_q + 3'd1;
                    ovf_d  = ovf_q | w_out_of_range;
                    if (!w_is_store) begin
                        acc_d = w_res;
                    end else begin
                        case (step_q[2:1])
                            2'd0:    rey_d = w_res;
                            2'd1:    imy_d = w_res;
                            2'd2:    rez_d = w_res;
                            default: imz_d = w_res;
                        endcase
                    end
                    if (step_q == 3'd7) begin
                        state_d = IDLE;
                        step_d  = 3'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            rey_q   <= '0;
            imy_q   <= '0;
            rez_q   <= '0;
            imz_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            rey_q   <= rey_d;
            imy_q   <= imy_d;
            rez_q   <= rez_d;
            imz_q   <= imz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.p_ready = (state_q == RUN);
    assign bus.step    = step_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.rey     = rey_q;
    assign bus.imy     = imy_q;
    assign bus.rez     = rez_q;
    assign bus.imz     = imz_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bfly_seq_alu
// Brief    : Drives three butterfly ALUs (wrap, saturate, scale) in lockstep
//            and compares their results against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bfly_seq_alu;
    localparam int W = 8;

    typedef struct {
        logic signed [W-1:0] rey;
        logic signed [W-1:0] imy;
        logic signed [W-1:0] rez;
        logic signed [W-1:0] imz;
        logic                ovf;
    } res_t;

    logic clock;
    logic n_rst;
    logic start;
    logic p_valid;
    logic signed [W-1:0] a_re, a_im, p_data;

    int   checks = 0;
    int   errors = 0;
    int   cur_p[8];
    res_t exp_q[$];

    fft_bfly_seq_alu_if #(.WIDTH(W)) if0 ();
    fft_bfly_seq_alu_if #(.WIDTH(W)) if1 ();
    fft_bfly_seq_alu_if #(.WIDTH(W)) if2 ();

    assign if0.start = start;   assign if1.start = start;   assign if2.start = start;
    assign if0.a_re = a_re;     assign if1.a_re = a_re;     assign if2.a_re = a_re;
    assign if0.a_im = a_im;     assign if1.a_im = a_im;     assign if2.a_im = a_im;
    assign if0.p_data = p_data; assign if1.p_data = p_data; assign if2.p_data = p_data;
    assign if0.p_valid = p_valid; assign if1.p_valid = p_valid; assign if2.p_valid = p_valid;

    fft_bfly_seq_alu #(.WIDTH(W), .SATURATE(0), .SCALE(0)) u_wrap (
        .clock(clock), .n_rst(n_rst), .bus(if0));
    fft_bfly_seq_alu #(.WIDTH(W), .SATURATE(1), .SCALE(0)) u_sat (
        .clock(clock), .n_rst(n_rst), .bus(if1));
    fft_bfly_seq_alu #(.WIDTH(W), .SATURATE(0), .SCALE(1)) u_scale (
        .clock(clock), .n_rst(n_rst), .bus(if2));

    logic signed [W-1:0] o_rey[3], o_imy[3], o_rez[3], o_imz[3];
    logic                o_ovf[3], o_done[3], o_busy[3], o_rdy[3];
    logic [2:0]          o_step[3];

    assign o_rey[0] = if0.rey;   assign o_rey[1] = if1.rey;   assign o_rey[2] = if2.rey;
    assign o_imy[0] = if0.imy;   assign o_imy[1] = if1.imy;   assign o_imy[2] = if2.imy;
    assign o_rez[0] = if0.rez;   assign o_rez[1] = if1.rez;   assign o_rez[2] = if2.rez;
    assign o_imz[0] = if0.imz;   assign o_imz[1] = if1.imz;   assign o_imz[2] = if2.imz;
    assign o_ovf[0] = if0.ovf;   assign o_ovf[1] = if1.ovf;   assign o_ovf[2] = if2.ovf;
    assign o_done[0] = if0.done; assign o_done[1] = if1.done; assign o_done[2] = if2.done;
    assign o_busy[0] = if0.busy; assign o_busy[1] = if1.busy; assign o_busy[2] = if2.busy;
    assign o_rdy[0] = if0.p_ready; assign o_rdy[1] = if1.p_ready; assign o_rdy[2] = if2.p_ready;
    assign o_step[0] = if0.step; assign o_step[1] = if1.step; assign o_step[2] = if2.step;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Straight-line arithmetic model of the eight steps on plain integers.
    function automatic res_t model(input int are, input int aim, input bit sat, input bit scl);
        res_t r;
        int   acc, opa, v;
        bit   sub;
        acc   = 0;
        r.ovf = 1'b0;
        r.rey = '0; r.imy = '0; r.rez = '0; r.imz = '0;
        for (int s = 0; s < 8; s++) begin
            opa = (s % 2 == 1) ? acc : (((s / 2) % 2 == 1) ? aim : are);
            sub = (s == 1) || (s == 4) || (s == 6) || (s == 7);
            v   = sub ? (opa - cur_p[s]) : (opa + cur_p[s]);
            if (scl && (s % 2 == 1)) v = v >>> 1;
            if (v > 127 || v < -128) begin
                r.ovf = 1'b1;
                if (sat) v = (v > 127) ? 127 : -128;
                else     v = ((v + 128) & 255) - 128;
            end
            case (s)
                1:       r.rey = 8'(v);
                3:       r.imy = 8'(v);
                5:       r.rez = 8'(v);
                7:       r.imz = 8'(v);
                default: acc = v;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller leaves the bench just before the start edge; returns in the done cycle.
    task automatic run_bfly(input int are, input int aim, input int stall_step,
                            input int stall_n, input bit midstart);
        res_t e[3];
        res_t g;
        e[0] = model(are, aim, 1'b0, 1'b0);
        e[1] = model(are, aim, 1'b1, 1'b0);
        e[2] = model(are, aim, 1'b0, 1'b1);
        for (int d = 0; d < 3; d++) exp_q.push_back(e[d]);

        start = 1'b1; a_re = 8'(are); a_im = 8'(aim); p_valid = 1'b0;
        tick();
        start = 1'b0;
        a_re  = 8'($urandom_range(0, 255));
        a_im  = 8'($urandom_range(0, 255));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_busy[d] !== 1'b1 || o_rdy[d] !== 1'b1 || o_step[d] !== 3'd0 ||
                o_ovf[d] !== 1'b0 || o_done[d] !== 1'b0) begin
                errors++;
                $display("FAIL accept dut%0d: busy=%b rdy=%b step=%0d ovf=%b done=%b, want 1 1 0 0 0",
                         d, o_busy[d], o_rdy[d], o_step[d], o_ovf[d], o_done[d]);
            end
        end

        for (int idx = 0; idx < 8; idx++) begin
            if (idx == stall_step) begin
                for (int k = 0; k < stall_n; k++) begin
                    p_valid = 1'b0;
                    p_data  = 8'($urandom_range(0, 255));
                    tick();
                    for (int d = 0; d < 3; d++) begin
                        checks++;
                        if (o_step[d] !== 3'(idx) || o_busy[d] !== 1'b1 || o_done[d] !== 1'b0 ||
                            (idx >= 2 && o_rey[d] !== e[d].rey)) begin
                            errors++;
                            $display("FAIL stall dut%0d: step=%0d busy=%b done=%b rey=%0d, want step=%0d busy=1 done=0 rey=%0d",
                                     d, o_step[d], o_busy[d], o_done[d], o_rey[d], idx, e[d].rey);
                        end
                    end
                end
            end
            p_valid = 1'b1;
            p_data  = 8'(cur_p[idx]);
            start   = midstart && (idx == 3);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (o_step[d] !== 3'(idx)) begin
                    errors++;
                    $display("FAIL step dut%0d: got %0d want %0d", d, o_step[d], idx);
                end
            end
            tick();
            start = 1'b0;
            if (idx < 7) begin
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (o_done[d] !== 1'b0 || o_busy[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL early_done dut%0d after step %0d: done=%b busy=%b, want 0 1",
                                 d, idx, o_done[d], o_busy[d]);
                    end
                end
            end
        end
        p_valid = 1'b0;

        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_done[d] !== 1'b1 || o_busy[d] !== 1'b0 || o_rdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL done dut%0d: done=%b busy=%b rdy=%b, want 1 0 0",
                         d, o_done[d], o_busy[d], o_rdy[d]);
            end
            g = exp_q.pop_front();
            checks++;
            if (o_rey[d] !== g.rey || o_imy[d] !== g.imy || o_rez[d] !== g.rez ||
                o_imz[d] !== g.imz || o_ovf[d] !== g.ovf) begin
                errors++;
                $display("FAIL result dut%0d: got rey=%0d imy=%0d rez=%0d imz=%0d ovf=%b want rey=%0d imy=%0d rez=%0d imz=%0d ovf=%b",
                         d, o_rey[d], o_imy[d], o_rez[d], o_imz[d], o_ovf[d],
                         g.rey, g.imy, g.rez, g.imz, g.ovf);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_rey[d] !== 8'sd0 || o_imy[d] !== 8'sd0 || o_rez[d] !== 8'sd0 ||
                o_imz[d] !== 8'sd0 || o_ovf[d] !== 1'b0 || o_done[d] !== 1'b0 ||
                o_busy[d] !== 1'b0 || o_rdy[d] !== 1'b0 || o_step[d] !== 3'd0) begin
                errors++;
                $display("FAIL %s dut%0d: rey=%0d imy=%0d rez=%0d imz=%0d ovf=%b done=%b busy=%b rdy=%b step=%0d, want all 0",
                         tag, d, o_rey[d], o_imy[d], o_rez[d], o_imz[d], o_ovf[d],
                         o_done[d], o_busy[d], o_rdy[d], o_step[d]);
            end
        end
    endtask

    task automatic set_basic_products();
        cur_p[0] = 20; cur_p[1] = 3; cur_p[2] = 4; cur_p[3] = 6;
        cur_p[4] = 20; cur_p[5] = 3; cur_p[6] = 4; cur_p[7] = 6;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b1; p_valid = 1'b1;
        a_re = 8'sd10; a_im = 8'sd5; p_data = 8'sd20;
        repeat (3) tick();
        check_cleared("reset_hold");
        start = 1'b0; p_valid = 1'b0;
        #2 n_rst = 1'b1;
        tick();
        check_cleared("reset_release");
    endtask

    task automatic test_basic();
        set_basic_products();
        run_bfly(10, 5, -1, 0, 1'b0);
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_done[d] !== 1'b0) begin
                errors++;
                $display("FAIL done_width dut%0d: done=%b want 0", d, o_done[d]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_stall();
        set_basic_products();
        run_bfly(10, 5, 2, 3, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cur_p[i] = 0;
        cur_p[0] = 100; cur_p[1] = -50;
        run_bfly(100, 0, -1, 0, 1'b0);
        tick();
        set_basic_products();
        run_bfly(10, 5, -1, 0, 1'b0);
        tick();
    endtask

    task automatic test_edge_negate();
        for (int i = 0; i < 8; i++) cur_p[i] = 0;
        cur_p[1] = -128;
        run_bfly(0, 0, -1, 0, 1'b0);
        tick();
    endtask

    task automatic test_midstart();
        set_basic_products();
        run_bfly(10, 5, -1, 0, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        set_basic_products();
        run_bfly(-128, 127, -1, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) cur_p[i] = int'($urandom_range(0, 255)) - 128;
            run_bfly(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_basic_products();
        start = 1'b1; a_re = 8'sd10; a_im = 8'sd5;
        tick();
        start = 1'b0;
        p_valid = 1'b1;
        for (int idx = 0; idx < 5; idx++) begin
            p_data = 8'(cur_p[idx]);
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_step[d] !== 3'd5) begin
                errors++;
                $display("FAIL pre_reset_step dut%0d: got %0d want 5", d, o_step[d]);
            end
        end
        #2 n_rst = 1'b0;
        #1 check_cleared("reset_mid");
        start = 1'b1;
        tick();
        check_cleared("reset_mid_hold");
        start = 1'b0; p_valid = 1'b0;
        #2 n_rst = 1'b1;
        repeat (2) tick();
        check_cleared("reset_mid_after");
    endtask

    initial begin
        start = 1'b0; p_valid = 1'b0; a_re = '0; a_im = '0; p_data = '0;
        n_rst = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_edge_negate();
        test_midstart();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
